// File: rtl/edit_sequencer.sv
// Button front end for the EditTime datapath: debounces mode/inc, walks RUN->SEC->MIN->HOUR,
// and generates set/increment/commit pulses with auto-repeat and an inactivity timeout.
module edit_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       set,
  output logic [1:0] select,
  output logic       increment,
  output logic       editing,
  output logic       commit
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RP_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_SEC = 2'd1, S_MIN = 2'd2, S_HOUR = 2'd3} state_t;

  // bit 0 = mode, bit 1 = inc
  logic [1:0]    raw;
  logic [1:0]    db_lvl;
  logic [1:0]    db_q;
  logic [1:0]    db_rise;
  logic [DW-1:0] db_cnt [2];

  assign raw = {btn_inc, btn_mode};

  always_ff @(posedge clk) begin
    if (reset) begin
      db_lvl  <= '0;
      db_q    <= '0;
      db_rise <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      db_q    <= db_lvl;
      db_rise <= db_lvl & ~db_q;
      for (int i = 0; i < 2; i++) begin
        if (raw[i] != db_lvl[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_lvl[i] <= raw[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  state_t        state;
  state_t        nxt_state;
  logic          mode_e;
  logic          inc_e;
  logic          inc_lvl;
  logic          rep_act;
  logic [RW-1:0] rep_cnt;
  logic [TW-1:0] to_cnt;

  assign mode_e    = db_rise[0];
  assign inc_e     = db_rise[1];
  assign inc_lvl   = db_lvl[1];
  assign nxt_state = state_t'(state + 2'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      select    <= 2'd0;
      editing   <= 1'b0;
      set       <= 1'b0;
      increment <= 1'b0;
      commit    <= 1'b0;
      rep_act   <= 1'b0;
      rep_cnt   <= '0;
      to_cnt    <= '0;
    end else begin
      set       <= 1'b0;
      increment <= 1'b0;
      commit    <= 1'b0;
      if (mode_e) begin
        // mode wins over a coincident inc edge or timeout
        state   <= nxt_state;
        select  <= nxt_state;
        editing <= (nxt_state != S_RUN);
        set     <= (state == S_RUN);
        commit  <= (state == S_HOUR);
        rep_act <= 1'b0;
        rep_cnt <= '0;
        to_cnt  <= '0;
      end else if (state == S_RUN) begin
        rep_act <= 1'b0;
        rep_cnt <= '0;
        to_cnt  <= '0;
      end else if (!inc_lvl && !inc_e && to_cnt == TO_LAST) begin
        state   <= S_RUN;
        select  <= 2'd0;
        editing <= 1'b0;
        commit  <= 1'b1;
        rep_act <= 1'b0;
        rep_cnt <= '0;
        to_cnt  <= '0;
      end else begin
        to_cnt <= (inc_lvl || inc_e) ? '0 : to_cnt + TW'(1);
        if (inc_e) begin
          increment <= 1'b1;
          rep_act   <= 1'b1;
          rep_cnt   <= '0;
        end else if (rep_act && inc_lvl) begin
          // after the first repeat, reload so later pulses come every REPEAT_PERIOD
          if (rep_cnt == RP_LAST) begin
            increment <= 1'b1;
            rep_cnt   <= RP_RELOAD;
          end else begin
            rep_cnt <= rep_cnt + RW'(1);
          end
        end else begin
          rep_act <= 1'b0;
          rep_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_edit_sequencer.sv
// Randomized and directed bench for edit_sequencer against an elapsed-time behavioural model.
module tb_edit_sequencer;
  localparam int DEB     = 4;
  localparam int DELAY   = 16;
  localparam int PERIOD  = 4;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic       set;
  logic [1:0] select;
  logic       increment;
  logic       editing;
  logic       commit;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  edit_sequencer #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .set(set), .select(select), .increment(increment), .editing(editing), .commit(commit)
  );

  always #5 clk = ~clk;

  // model state: debounced level, previous level, rise pulse and mismatch streak per button
  int m_db [2];
  int m_dbq [2];
  int m_rise [2];
  int m_streak [2];
  int m_st, m_idle, m_armed;
  int m_set, m_inc, m_commit;
  int m_nset = 0, m_ninc = 0, m_ncommit = 0;
  int m_t_set = 0, m_t_commit = 0, m_t_incraw = 0;
  int prev_raw_inc = 0;
  int d_nset = 0, d_ninc = 0, d_ncommit = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    int raw [2];
    int mode_e, inc_e, lvl, k;
    m_set = 0; m_inc = 0; m_commit = 0;
    raw[0] = int'(btn_mode);
    raw[1] = int'(btn_inc);
    if (raw[1] == 1 && prev_raw_inc == 0) m_t_incraw = cyc;
    prev_raw_inc = raw[1];
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_db[i] = 0; m_dbq[i] = 0; m_rise[i] = 0; m_streak[i] = 0;
      end
      m_st = 0; m_idle = 0; m_armed = -1;
      return;
    end
    mode_e = m_rise[0];
    inc_e  = m_rise[1];
    lvl    = m_db[1];
    if (mode_e != 0) begin
      if (m_st == 0) m_set = 1;
      if (m_st == 3) m_commit = 1;
      m_st = (m_st + 1) % 4;
      m_armed = -1;
      m_idle = 0;
    end else if (m_st != 0) begin
      if (lvl != 0 || inc_e != 0) m_idle = 0;
      else m_idle++;
      if (m_idle == TIMEOUT) begin
        m_commit = 1; m_st = 0; m_armed = -1; m_idle = 0;
      end else if (inc_e != 0) begin
        m_inc = 1;
        m_armed = cyc;
      end else if (m_armed >= 0 && lvl != 0) begin
        k = cyc - m_armed;
        if (k == DELAY || (k > DELAY && (k - DELAY) % PERIOD == 0)) m_inc = 1;
      end else begin
        m_armed = -1;
      end
    end else begin
      m_idle = 0;
      m_armed = -1;
    end
    for (int i = 0; i < 2; i++) begin
      m_rise[i] = (m_db[i] != 0 && m_dbq[i] == 0) ? 1 : 0;
      m_dbq[i] = m_db[i];
      if (raw[i] != m_db[i]) begin
        m_streak[i]++;
        if (m_streak[i] == DEB) begin
          m_db[i] = raw[i];
          m_streak[i] = 0;
        end
      end else begin
        m_streak[i] = 0;
      end
    end
    m_nset += m_set; m_ninc += m_inc; m_ncommit += m_commit;
    if (m_set != 0) m_t_set = cyc;
    if (m_commit != 0) m_t_commit = cyc;
  endtask

  always @(posedge clk) begin
    model_step();
    cyc++;
    #1;
    chk("set", int'(set), m_set);
    chk("increment", int'(increment), m_inc);
    chk("commit", int'(commit), m_commit);
    chk("select", int'(select), m_st);
    chk("editing", int'(editing), (m_st != 0) ? 1 : 0);
    chk("pulse_exclusive", (int'(set) + int'(increment) + int'(commit) <= 1) ? 1 : 0, 1);
    d_nset += int'(set); d_ninc += int'(increment); d_ncommit += int'(commit);
  end

  task automatic press(input bit which, input int hold, input int gap);
    @(negedge clk);
    if (which) btn_inc = 1'b1; else btn_mode = 1'b1;
    repeat (hold) @(negedge clk);
    if (which) btn_inc = 1'b0; else btn_mode = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_set, s_inc, s_com, ds_set, ds_inc, ds_com;
    int exp_sel [4];
    exp_sel[0] = 1; exp_sel[1] = 2; exp_sel[2] = 3; exp_sel[3] = 0;
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_select", int'(select), 0);
    chk("reset_model_state", m_st, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // bouncing mode press enters SEC with one set pulse
    s_set = m_nset; ds_set = d_nset;
    btn_mode = 1'b1; @(negedge clk);
    btn_mode = 1'b0; @(negedge clk);
    btn_mode = 1'b1; repeat (10) @(negedge clk);
    btn_mode = 1'b0; repeat (10) @(negedge clk);
    chk("bounce_set_model", m_nset - s_set, 1);
    chk("bounce_set_dut", d_nset - ds_set, 1);
    chk("bounce_select", int'(select), 1);
    chk("bounce_editing", int'(editing), 1);

    // short press filtered, 6-cycle press gives one increment
    s_inc = m_ninc; ds_inc = d_ninc;
    press(1'b1, 3, 10);
    chk("short_inc_model", m_ninc - s_inc, 0);
    press(1'b1, 6, 10);
    chk("one_inc_model", m_ninc - s_inc, 1);
    chk("one_inc_dut", d_ninc - ds_inc, 1);

    // auto-repeat in MIN
    press(1'b0, 6, 10);
    s_inc = m_ninc; ds_inc = d_ninc;
    press(1'b1, 36, 12);
    chk("repeat_model", m_ninc - s_inc, 6);
    chk("repeat_dut", d_ninc - ds_inc, 6);
    chk("repeat_select", int'(select), 2);
    press(1'b0, 6, 10);
    press(1'b0, 6, 10);
    chk("back_to_run", int'(select), 0);

    // four mode presses cycle the fields
    s_set = m_nset; s_com = m_ncommit; ds_com = d_ncommit;
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 6, 10);
      chk("cycle_select", int'(select), exp_sel[i]);
    end
    chk("cycle_set_model", m_nset - s_set, 1);
    chk("cycle_commit_model", m_ncommit - s_com, 1);
    chk("cycle_commit_dut", d_ncommit - ds_com, 1);
    chk("cycle_editing", int'(editing), 0);

    // plain timeout
    s_com = m_ncommit; ds_com = d_ncommit;
    press(1'b0, 6, 80);
    chk("timeout_delay", m_t_commit - m_t_set, 64);
    chk("timeout_commit_dut", d_ncommit - ds_com, 1);
    chk("timeout_select", int'(select), 0);

    // inc press around cycle 50 restarts the timeout
    s_com = m_ncommit;
    press(1'b0, 6, 10);
    repeat (39) @(negedge clk);
    press(1'b1, 6, 90);
    chk("timeout_restart", m_t_commit - m_t_incraw, 73);
    chk("timeout_restart_once", m_ncommit - s_com, 1);

    // mode and inc together in HOUR: commit only
    for (int i = 0; i < 3; i++) press(1'b0, 6, 10);
    s_inc = m_ninc; s_com = m_ncommit; ds_inc = d_ninc; ds_com = d_ncommit;
    @(negedge clk);
    btn_mode = 1'b1; btn_inc = 1'b1;
    repeat (6) @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    chk("simul_commit_model", m_ncommit - s_com, 1);
    chk("simul_commit_dut", d_ncommit - ds_com, 1);
    chk("simul_no_inc_model", m_ninc - s_inc, 0);
    chk("simul_no_inc_dut", d_ninc - ds_inc, 0);

    // reset in MIN: no commit
    press(1'b0, 6, 10);
    press(1'b0, 6, 10);
    s_com = m_ncommit; ds_com = d_ncommit;
    reset = 1'b1;
    @(posedge clk); #2;
    chk("reset_mid_select", int'(select), 0);
    chk("reset_mid_editing", int'(editing), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_no_commit", d_ncommit - ds_com, 0);
    chk("reset_no_commit_model", m_ncommit - s_com, 0);

    // random bouncy buttons
    for (int n = 0; n < 400; n++) begin
      btn_mode = ($urandom_range(0, 9) < 3);
      btn_inc  = ($urandom_range(0, 9) < 4);
      reset    = ($urandom_range(0, 199) == 0);
      repeat ($urandom_range(1, 14)) @(negedge clk);
      reset = 1'b0;
    end
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (100) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
